reg_bank: RTL and testbench

//  32 x 32-bit MIPS general-purpose register file. Direct downstream consumer of the

---
 rtl/reg_bank_pkg.sv | 15 +
 rtl/reg_bank_if.sv | 25 ++
 rtl/reg_bank.sv | 56 +++++
 tb/tb_reg_bank.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared register-file constants for the MIPS datapath.
// The RegDst mux imports the same indices so both blocks agree.
package reg_bank_pkg;
  localparam int          DEF_DATA_W  = 32;
  localparam int          DEF_ADDR_W  = 5;
  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam logic [4:0]  REG_SP      = 5'd29;
  localparam logic [4:0]  REG_RA      = 5'd31;
  localparam logic [31:0] SP_INIT_DEF = 32'd227;

  // Reset contents of register idx: $sp is preloaded, everything else clears.
  function automatic logic [31:0] reset_val(input int idx, input logic [31:0] sp_init);
    return (idx == int'(REG_SP)) ? sp_init : 32'd0;
  endfunction
endpackage

// File: rtl/reg_bank_if.sv
// Read/write-back port bundle of the register file.
interface reg_bank_if
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              reg_write;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  modport master (
    output reg_write, read_reg1, read_reg2, write_reg, write_data,
    input  read_data1, read_data2
  );

  modport slave (
    input  reg_write, read_reg1, read_reg2, write_reg, write_data,
    output read_data1, read_data2
  );
endinterface

// File: rtl/reg_bank.sv
// 32 x 32 MIPS register file: two combinational read ports, one clocked write port,
// $zero hardwired, $sp preloaded on reset, optional write-first bypass.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF),
  parameter bit                BYPASS  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  reg_bank_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;

  // r0 is a constant, so storage starts at index 1.
  logic [DATA_W-1:0] r_regs [1:NREG-1];
  logic              w_wr_en;

  assign w_wr_en = reset && bus.reg_write && (bus.write_reg != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++)
        r_regs[i] <= DATA_W'(reset_val(i, 32'(SP_INIT)));
    end else if (w_wr_en) begin
      r_regs[bus.write_reg] <= bus.write_data;
    end
  end

  // Bypass is gated by reset so reads during reset show the reset contents.
  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] idx,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_idx,
    input logic [DATA_W-1:0] wr_data
  );
    if (idx == '0)
      return '0;
    if (BYPASS && wr_en && (wr_idx == idx))
      return wr_data;
    return r_regs[idx];
  endfunction

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  always_comb begin
    w_rd1 = rd_port(bus.read_reg1, w_wr_en, bus.write_reg, bus.write_data);
    w_rd2 = rd_port(bus.read_reg2, w_wr_en, bus.write_reg, bus.write_data);
  end

  assign bus.read_data1 = w_rd1;
  assign bus.read_data2 = w_rd2;
endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: bypass and non-bypass instances share one stimulus,
// expected read data is queued at drive time and compared once reads settle.
module tb_reg_bank;
  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd;

  logic [31:0] mdl [32];
  int          n_chk  = 0;
  int          n_pass = 0;

  typedef struct {
    string       tag;
    logic [31:0] e0, e1, e2, e3;
  } exp_t;
  exp_t sb [$];

  reg_bank_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
  reg_bank_if #(.DATA_W(32), .ADDR_W(5)) if_n ();

  assign if_b.reg_write  = we;
  assign if_b.read_reg1  = ra1;
  assign if_b.read_reg2  = ra2;
  assign if_b.write_reg  = wa;
  assign if_b.write_data = wd;
  assign if_n.reg_write  = we;
  assign if_n.read_reg1  = ra1;
  assign if_n.read_reg2  = ra2;
  assign if_n.write_reg  = wa;
  assign if_n.write_data = wd;

  reg_bank #(.BYPASS(1'b1)) u_byp   (.clk(clk), .reset(rst), .bus(if_b.slave));
  reg_bank #(.BYPASS(1'b0)) u_nobyp (.clk(clk), .reset(rst), .bus(if_n.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit bp);
    if (idx == 5'd0) return 32'd0;
    if (bp && rst && we && (wa == idx)) return wd;
    return mdl[idx];
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl[29] = 32'd227;
  endtask

  task automatic chk(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    exp_t        e, g;
    logic [31:0] obs [4];
    logic [31:0] ex  [4];
    ra1 = a1;
    ra2 = a2;
    e.tag = tag;
    e.e0  = exp_rd(a1, 1'b1);
    e.e1  = exp_rd(a2, 1'b1);
    e.e2  = exp_rd(a1, 1'b0);
    e.e3  = exp_rd(a2, 1'b0);
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    obs[0] = if_b.read_data1; obs[1] = if_b.read_data2;
    obs[2] = if_n.read_data1; obs[3] = if_n.read_data2;
    ex[0] = g.e0; ex[1] = g.e1; ex[2] = g.e2; ex[3] = g.e3;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      assert (obs[k] === ex[k]) n_pass++;
      else $error("FAIL %s port%0d got %h want %h", g.tag, k, obs[k], ex[k]);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk);
    if (rst && a != 5'd0) mdl[a] = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    mdl_reset();

    // reset asserted between edges: contents visible with no clock
    #2 rst = 1'b0;
    mdl_reset();
    chk("rst_r0_r29", 5'd0, 5'd29);
    chk("rst_r31_r1", 5'd31, 5'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rel_r31", 5'd31, 5'd29);

    wr(5'd8, 32'hDEADBEEF);
    chk("wr_r8_r9", 5'd8, 5'd9);

    wr(5'd0, 32'hFFFFFFFF);
    chk("zero_both", 5'd0, 5'd0);
    chk("zero_others", 5'd8, 5'd29);

    // same-cycle read of the write target
    @(negedge clk);
    we = 1'b1; wa = 5'd31; wd = 32'h00400010;
    chk("byp_pre", 5'd31, 5'd31);
    chk("byp_mix", 5'd31, 5'd8);
    @(posedge clk);
    mdl[31] = wd;
    @(negedge clk);
    we = 1'b0;
    chk("byp_post", 5'd31, 5'd31);

    // reset wins over a coincident write
    wr(5'd29, 32'h00000100);
    chk("sp_written", 5'd29, 5'd8);
    @(negedge clk);
    we = 1'b1; wa = 5'd29; wd = 32'h00000200; rst = 1'b0;
    mdl_reset();
    chk("rst_pre", 5'd29, 5'd8);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; we = 1'b0;
    chk("rst_drop", 5'd29, 5'd8);
    wr(5'd9, 32'h00000055);
    chk("first_wr", 5'd9, 5'd29);

    wr(5'd5, 32'hAAAA0000);
    wr(5'd5, 32'h0000BBBB);
    chk("b2b_last", 5'd5, 5'd5);

    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 4 + 1));
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      chk($sformatf("sweep_%0d", i), 5'(i), 5'(32 - i));
    end
    chk("sweep_r0", 5'd0, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
